spi_master_regif: RTL and testbench

SPI master that runs one register access per request against the SPI register slave: one write or one read of an 8-bit register at an 8-bit address. It generates spi_clk, the active-low chip select and MOSI, and samples MISO. All four SPI modes are selected per transfer with cpol/cpha. It sits on the host side of the SPI link and is driven by a simple start/busy/done command port from local control logic.

---
 rtl/spi_master_regif.sv | 137 +++++++++++++
 tb/tb_spi_master_regif.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_regif.sv
// spi_master_regif: SPI master issuing one 24-bit register access per request
// (command byte, address byte, data byte). Supports all four SPI modes per
// transfer. Frame timing: SETUP half-period, 48 SPI half-periods, HOLD
// half-period with cs low, then a GAP half-period before the next request.
module spi_master_regif #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       spi_clk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  localparam int            CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [5:0]    EDGE_LAST = 6'd47;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    edge_q;
  logic [23:0]   sr_q, frame_d;
  logic          cpol_q, cpha_q, rw_q;
  logic          busy_q, done_q, sclk_q, cs_q, mosi_q;
  logic [7:0]    rdata_q;
  logic          hp_end, lead, shift_ev, drive_ev;

  // Frame word for a new request: command, address, write data (zero on reads)
  always_comb begin
    frame_d = {(rw ? 8'h03 : 8'h02), addr, (rw ? 8'h00 : wdata)};
  end

  // Half-period counter and classification of the spi_clk edge about to happen.
  // edge_q counts edges already made, so the next edge is odd (leading) when
  // edge_q is even. MISO is sampled on the capture edge, MOSI moves on the
  // other one; in cpha=0 the final trailing edge must not advance MOSI.
  always_comb begin
    hp_end   = (cnt_q == CNT_LAST);
    cnt_d    = hp_end ? '0 : cnt_q + CW'(1);
    lead     = ~edge_q[0];
    shift_ev = (lead != cpha_q);
    drive_ev = (lead == cpha_q) && (cpha_q || (edge_q != EDGE_LAST));
  end

  // Frame sequencer: SPI pin drive, shift register and host handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      sr_q    <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      rw_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q  <= '0;
          sclk_q <= cpol;
          if (start) begin
            state_q <= S_SETUP;
            sr_q    <= frame_d;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            rw_q    <= rw;
            busy_q  <= 1'b1;
            cs_q    <= 1'b0;
            mosi_q  <= frame_d[23];
          end
        end
        S_SETUP: begin
          cnt_q  <= cnt_d;
          sclk_q <= cpol_q;
          if (hp_end) begin
            state_q <= S_SHIFT;
            edge_q  <= '0;
          end
        end
        S_SHIFT: begin
          cnt_q <= cnt_d;
          if (hp_end) begin
            sclk_q <= ~sclk_q;
            edge_q <= edge_q + 6'd1;
            if (shift_ev) sr_q   <= {sr_q[22:0], miso};
            if (drive_ev) mosi_q <= sr_q[23];
            if (edge_q == EDGE_LAST) state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          cnt_q  <= cnt_d;
          sclk_q <= cpol_q;
          if (hp_end) begin
            state_q <= S_GAP;
            cs_q    <= 1'b1;
            done_q  <= 1'b1;
            if (rw_q) rdata_q <= sr_q[7:0];
          end
        end
        S_GAP: begin
          cnt_q <= cnt_d;
          if (hp_end) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign spi_clk = sclk_q;
  assign cs      = cs_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_regif.sv
// Bench for spi_master_regif: cycle-level reference model derived from frame
// timing arithmetic, a behavioural SPI slave, and directed register accesses.
module tb_spi_master_regif;
  localparam int CD = 4;

  logic       clk = 1'b0, reset = 1'b1;
  logic       cpol = 1'b0, cpha = 1'b0, start = 1'b0, rw = 1'b0, miso = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00;
  logic       busy, done, spi_clk, cs, mosi;
  logic [7:0] rdata;

  int checks = 0, failures = 0, cyc = 0, n_done = 0;

  spi_master_regif #(.CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .start(start),
    .rw(rw), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .spi_clk(spi_clk), .cs(cs), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done === 1'b1) n_done++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_act = 1'b0, m_cpol = 1'b0, m_cpha = 1'b0, m_rw = 1'b0;
  int          m_d = 0;
  logic [23:0] m_frame = '0;
  logic [7:0]  m_rx = 8'h00, slave_ret = 8'h00;
  logic        e_busy = 1'b0, e_done = 1'b0, e_cs = 1'b1, e_sclk = 1'b0;
  logic        e_mosi = 1'b0, e_mchk = 1'b1;
  logic [7:0]  e_rdata = 8'h00;

  // spi_clk edges seen by cycle d of a frame (d=1 is the first cs-low cycle)
  function automatic int n_edges(input int d);
    int n;
    if (d <= 2*CD) return 0;
    n = (d - 1) / CD - 1;
    return (n > 48) ? 48 : n;
  endfunction

  // frame bit on MOSI after n edges
  function automatic int mosi_bit(input int n, input logic ph);
    if (!ph) return 23 - (((n / 2) > 23) ? 23 : (n / 2));
    if (n == 0) return 23;
    return 23 - (n - 1) / 2;
  endfunction

  task automatic m_eval();
    int n;
    n      = n_edges(m_d);
    e_busy = 1'b1;
    e_cs   = (m_d > 50*CD);
    e_done = (m_d == 50*CD + 1);
    e_sclk = m_cpol ^ n[0];
    e_mchk = (m_d <= 50*CD);
    e_mosi = m_frame[mosi_bit(n, m_cpha)];
    if (m_d == 50*CD + 1 && m_rw) e_rdata = m_rx;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_act = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_cs = 1'b1;
      e_sclk = 1'b0; e_mosi = 1'b0; e_mchk = 1'b1; e_rdata = 8'h00;
    end else if (m_act && m_d == 51*CD) begin
      m_act = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_cs = 1'b1; e_mchk = 1'b0;
    end else if (m_act) begin
      m_d++;
      m_eval();
    end else begin
      e_busy = 1'b0; e_done = 1'b0; e_cs = 1'b1; e_sclk = cpol; e_mchk = 1'b0;
      if (start) begin
        m_act = 1'b1; m_d = 1;
        m_cpol = cpol; m_cpha = cpha; m_rw = rw; m_rx = slave_ret;
        m_frame = {(rw ? 8'h03 : 8'h02), addr, (rw ? 8'h00 : wdata)};
        m_eval();
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("cs", 32'(cs), 32'(e_cs));
      chk("spi_clk", 32'(spi_clk), 32'(e_sclk));
      chk("rdata", 32'(rdata), 32'(e_rdata));
      if (e_mchk) chk("mosi", 32'(mosi), 32'(e_mosi));
    end
  end

  // ---------------- behavioural SPI slave ----------------
  logic [23:0] s_out = '0, s_cap = '0;
  int          s_idx = 0, s_rise = 0;
  logic        cs_prev = 1'b1, sclk_prev = 1'b0;

  always @(cs or spi_clk) begin
    if (cs_prev === 1'b1 && cs === 1'b0) begin
      s_out  = {16'hE71B, m_rx};
      s_cap  = '0;
      s_rise = 0;
      miso   = s_out[23];
      s_idx  = m_cpha ? 23 : 22;
    end else if (cs === 1'b0 && spi_clk !== sclk_prev) begin
      if ((spi_clk !== m_cpol) ^ m_cpha) s_cap = {s_cap[22:0], mosi};
      else if (s_idx >= 0) begin
        miso = s_out[s_idx];
        s_idx--;
      end
      if (spi_clk === 1'b1) s_rise++;
    end
    cs_prev   = cs;
    sclk_prev = spi_clk;
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_frame(input logic r, cp, ch, input logic [7:0] a, w, ret,
                             output int t);
    cpol = cp; cpha = ch; rw = r; addr = a; wdata = w; slave_ret = ret;
    @(negedge clk);
    start = 1'b1;
    t = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(output int bc);
    bc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        bc = cyc;
        break;
      end
    end
    if (bc < 0) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_basic(input string tag, input logic r, cp, ch,
                           input logic [7:0] a, w, ret,
                           input logic [23:0] xcap, input logic [7:0] xrd);
    int t, dc, bc;
    cpol = cp;
    @(negedge clk);
    chk({tag, "_sclk_idle_pre"}, 32'(spi_clk), 32'(cp));
    start_frame(r, cp, ch, a, w, ret, t);
    wait_done(dc);
    chk({tag, "_done_latency"}, dc - t, 32'd201);
    chk({tag, "_mosi_stream"}, 32'(s_cap), 32'(xcap));
    chk({tag, "_sclk_rises"}, s_rise, 32'd24);
    chk({tag, "_rdata"}, 32'(rdata), 32'(xrd));
    wait_idle(bc);
    chk({tag, "_busy_fall"}, bc - t, 32'd205);
    @(negedge clk);
    chk({tag, "_sclk_idle_post"}, 32'(spi_clk), 32'(cp));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t, dc, dc2, bc, csf, nd0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'h00);
    chk("rst_sclk", 32'(spi_clk), 32'd0);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_mosi", 32'(mosi), 32'd0);
    reset = 1'b0;

    run_basic("wr_m0", 1'b0, 1'b0, 1'b0, 8'h12, 8'hA5, 8'h66, 24'h0212A5, 8'h00);
    run_basic("rd_m0", 1'b1, 1'b0, 1'b0, 8'h34, 8'h00, 8'h3C, 24'h033400, 8'h3C);
    run_basic("rd_m3", 1'b1, 1'b1, 1'b1, 8'h7F, 8'h00, 8'hC3, 24'h037F00, 8'hC3);
    run_basic("wr_m1", 1'b0, 1'b0, 1'b1, 8'h5A, 8'h81, 8'h0F, 24'h025A81, 8'hC3);
    run_basic("rd_m2", 1'b1, 1'b1, 1'b0, 8'hC0, 8'h00, 8'h7E, 24'h03C000, 8'h7E);

    // start while busy must be ignored
    start_frame(1'b0, 1'b0, 1'b0, 8'h21, 8'h5E, 8'h11, t);
    nd0 = n_done;
    while (cyc < t + 50) @(negedge clk);
    start = 1'b1; addr = 8'h99; wdata = 8'h00; rw = 1'b1; cpha = 1'b1; cpol = 1'b1;
    @(negedge clk);
    start = 1'b0; cpol = 1'b0; cpha = 1'b0; rw = 1'b0;
    wait_done(dc);
    chk("busy_start_latency", dc - t, 32'd201);
    chk("busy_start_stream", 32'(s_cap), 32'h02215E);
    while (cyc < t + 460) @(negedge clk);
    chk("busy_start_dones", n_done - nd0, 32'd1);

    // reset in the middle of a frame
    start_frame(1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h99, t);
    while (cyc < t + 100) @(negedge clk);
    chk("midrst_in_frame", 32'(cs), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_cs", 32'(cs), 32'd1);
    chk("midrst_sclk", 32'(spi_clk), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mosi", 32'(mosi), 32'd0);
    chk("midrst_rdata", 32'(rdata), 32'h00);
    reset = 1'b0;
    nd0 = n_done;
    repeat (300) @(negedge clk);
    chk("midrst_no_done", n_done - nd0, 32'd0);

    // back-to-back with start held high
    cpol = 1'b0; cpha = 1'b0; rw = 1'b0; addr = 8'h55; wdata = 8'hAA; slave_ret = 8'h00;
    @(negedge clk);
    nd0 = n_done;
    start = 1'b1;
    t = cyc;
    wait_done(dc);
    chk("b2b_first_done", dc - t, 32'd201);
    csf = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cs === 1'b0) begin
        csf = cyc;
        break;
      end
    end
    chk("b2b_cs_refall", csf - dc, 32'd5);
    wait_done(dc2);
    start = 1'b0;
    chk("b2b_done_spacing", dc2 - dc, 32'd205);
    chk("b2b_stream", 32'(s_cap), 32'h0255AA);
    wait_idle(bc);
    repeat (20) @(negedge clk);
    chk("b2b_dones", n_done - nd0, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
